// File: rtl/sctag_pcx_rptr_pipe.sv
// Registered long-haul repeater between the crossbar and sctag: a chain of two-entry
// skid-buffer stages, so neither valid nor stall has a combinational path through the block.
module sctag_pcx_rptr_pipe #(
    parameter int WIDTH  = 164,
    parameter int STAGES = 2,
    parameter int OCCW   = 3
) (
    input  logic             rclk,
    input  logic             arst_l,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_vld,
    output logic             in_stall,
    output logic [WIDTH-1:0] out_data,
    output logic             out_vld,
    input  logic             out_stall,
    output logic [OCCW-1:0]  occ
);

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } st_e;

    logic [STAGES-1:0] vld_s;
    logic [STAGES-1:0] rdy_s;
    logic [STAGES-1:0] up_vld_s;
    logic [STAGES-1:0] dn_rdy_s;
    logic [WIDTH-1:0]  m_s       [STAGES];
    logic [WIDTH-1:0]  up_data_s [STAGES];
    logic              in_xfer_s;
    logic              out_xfer_s;
    logic [OCCW-1:0]   occ_q;
    logic [OCCW-1:0]   occ_d;

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        st_e              state_q;
        logic [WIDTH-1:0] m_q;
        logic [WIDTH-1:0] s_q;
        logic             push_s;
        logic             pop_s;

        if (k == 0) begin : g_head
            assign up_vld_s[k]  = in_vld;
            assign up_data_s[k] = in_data;
        end else begin : g_link
            assign up_vld_s[k]  = vld_s[k-1];
            assign up_data_s[k] = m_s[k-1];
        end

        if (k == STAGES - 1) begin : g_tail
            assign dn_rdy_s[k] = ~out_stall;
        end else begin : g_fwd
            assign dn_rdy_s[k] = rdy_s[k+1];
        end

        // Ready and valid come straight from the state flop, never from neighbours.
        assign rdy_s[k] = (state_q != ST_TWO);
        assign vld_s[k] = (state_q != ST_EMPTY);
        assign m_s[k]   = m_q;
        assign push_s   = up_vld_s[k] & rdy_s[k];
        assign pop_s    = vld_s[k] & dn_rdy_s[k];

        // Per-stage skid FSM: M is always the head, S catches the item that arrives while stalled.
        always_ff @(posedge rclk or negedge arst_l) begin
            if (!arst_l) begin
                state_q <= ST_EMPTY;
                m_q     <= '0;
                s_q     <= '0;
            end else begin
                case (state_q)
                    ST_EMPTY: begin
                        if (push_s) begin
                            state_q <= ST_ONE;
                            m_q     <= up_data_s[k];
                        end
                    end
                    ST_ONE: begin
                        if (push_s && pop_s) begin
                            m_q <= up_data_s[k];
                        end else if (push_s) begin
                            state_q <= ST_TWO;
                            s_q     <= up_data_s[k];
                        end else if (pop_s) begin
                            state_q <= ST_EMPTY;
                        end
                    end
                    ST_TWO: begin
                        if (pop_s) begin
                            state_q <= ST_ONE;
                            m_q     <= s_q;
                        end
                    end
                    default: begin
                        state_q <= ST_EMPTY;
                    end
                endcase
            end
        end
    end

    assign in_xfer_s  = in_vld & rdy_s[0];
    assign out_xfer_s = vld_s[STAGES-1] & ~out_stall;

    // Internal hand-offs are occupancy-neutral, so only the boundary transfers move the count.
    always_comb begin
        occ_d = occ_q;
        if (in_xfer_s && !out_xfer_s) begin
            occ_d = occ_q + OCCW'(1);
        end else if (!in_xfer_s && out_xfer_s) begin
            occ_d = occ_q - OCCW'(1);
        end else begin
            occ_d = occ_q;
        end
    end

    // Occupancy register, updated on the same edge as the stage state flops.
    always_ff @(posedge rclk or negedge arst_l) begin
        if (!arst_l) begin
            occ_q <= '0;
        end else begin
            occ_q <= occ_d;
        end
    end

    assign in_stall = ~rdy_s[0];
    assign out_vld  = vld_s[STAGES-1];
    assign out_data = m_s[STAGES-1];
    assign occ      = occ_q;

endmodule

// File: tb/tb_sctag_pcx_rptr_pipe.sv
// Bench for sctag_pcx_rptr_pipe: directed scenarios on a 164-bit/2-stage instance and a
// randomized queue-scoreboard sweep on 8-bit instances with 1 and 4 stages.
module tb_sctag_pcx_rptr_pipe;

    logic clk    = 1'b0;
    logic arst_l = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    logic [163:0] d2, od2;
    logic         v2, s2, is2, ov2;
    logic [2:0]   occ2;
    logic [7:0]   d1, od1;
    logic         v1, s1, is1, ov1;
    logic [2:0]   occ1;
    logic [7:0]   d4, od4;
    logic         v4, s4, is4, ov4;
    logic [3:0]   occ4;

    sctag_pcx_rptr_pipe #(.WIDTH(164), .STAGES(2), .OCCW(3)) dut2 (
        .rclk(clk), .arst_l(arst_l), .in_data(d2), .in_vld(v2), .in_stall(is2),
        .out_data(od2), .out_vld(ov2), .out_stall(s2), .occ(occ2));
    sctag_pcx_rptr_pipe #(.WIDTH(8), .STAGES(1), .OCCW(3)) dut1 (
        .rclk(clk), .arst_l(arst_l), .in_data(d1), .in_vld(v1), .in_stall(is1),
        .out_data(od1), .out_vld(ov1), .out_stall(s1), .occ(occ1));
    sctag_pcx_rptr_pipe #(.WIDTH(8), .STAGES(4), .OCCW(4)) dut4 (
        .rclk(clk), .arst_l(arst_l), .in_data(d4), .in_vld(v4), .in_stall(is4),
        .out_data(od4), .out_vld(ov4), .out_stall(s4), .occ(occ4));

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        v2 = 1'b0; s2 = 1'b0; d2 = '0;
        v1 = 1'b0; s1 = 1'b0; d1 = '0;
        v4 = 1'b0; s4 = 1'b0; d4 = '0;
    endtask

    task automatic do_reset();
        idle_inputs();
        #2 arst_l = 1'b0;
        #3 arst_l = 1'b1;
        step();
    endtask

    task automatic test_reset();
        idle_inputs();
        #1;
        total++; if (ov2 !== 1'b0) begin bad++; $display("FAIL rst_ov2 got=%0h exp=0", ov2); end
        total++; if (is2 !== 1'b0) begin bad++; $display("FAIL rst_is2 got=%0h exp=0", is2); end
        total++; if (occ2 !== 3'd0) begin bad++; $display("FAIL rst_occ2 got=%0h exp=0", occ2); end
        total++; if (od2 !== 164'd0) begin bad++; $display("FAIL rst_od2 got=%0h exp=0", od2); end
        total++; if (ov1 !== 1'b0 || ov4 !== 1'b0) begin bad++; $display("FAIL rst_ov14 got=%0h/%0h exp=0", ov1, ov4); end
        total++; if (occ1 !== 3'd0 || occ4 !== 4'd0) begin bad++; $display("FAIL rst_occ14 got=%0h/%0h exp=0", occ1, occ4); end
        @(negedge clk);
        arst_l = 1'b1;
        step();
        total++; if (ov2 !== 1'b0 || is2 !== 1'b0) begin bad++; $display("FAIL rst_release got=%0h/%0h exp=0", ov2, is2); end
    endtask

    task automatic test_streaming();
        int exp_occ;
        logic exp_v;
        do_reset();
        for (int i = 0; i < 15; i++) begin
            v2 = (i < 10);
            d2 = 164'(i + 1);
            s2 = 1'b0;
            exp_v   = (i >= 2 && i < 12);
            exp_occ = (i == 0) ? 0 : (i == 1) ? 1 : (i <= 10) ? 2 : (i == 11) ? 1 : 0;
            total++; if (ov2 !== exp_v) begin bad++; $display("FAIL stream_vld c=%0d got=%0h exp=%0h", i, ov2, exp_v); end
            if (exp_v) begin
                total++; if (od2 !== 164'(i - 1)) begin bad++; $display("FAIL stream_data c=%0d got=%0h exp=%0h", i, od2, i - 1); end
            end
            total++; if (occ2 !== 3'(exp_occ)) begin bad++; $display("FAIL stream_occ c=%0d got=%0d exp=%0d", i, occ2, exp_occ); end
            total++; if (is2 !== 1'b0) begin bad++; $display("FAIL stream_stall c=%0d got=%0h exp=0", i, is2); end
            step();
        end
        v2 = 1'b0;
    endtask

    task automatic test_backpressure();
        int nxt;
        logic [163:0] got[$];
        do_reset();
        s2  = 1'b1;
        nxt = 1;
        for (int c = 0; c < 8; c++) begin
            v2 = 1'b1;
            d2 = 164'(nxt);
            if (!is2) nxt++;
            step();
        end
        total++; if (nxt - 1 != 4) begin bad++; $display("FAIL bp_accepted got=%0d exp=4", nxt - 1); end
        total++; if (occ2 !== 3'd4) begin bad++; $display("FAIL bp_occ got=%0d exp=4", occ2); end
        total++; if (is2 !== 1'b1) begin bad++; $display("FAIL bp_in_stall got=%0h exp=1", is2); end
        v2 = 1'b0;
        s2 = 1'b0;
        for (int c = 0; c < 7; c++) begin
            if (ov2) got.push_back(od2);
            step();
        end
        total++; if (got.size() != 4) begin bad++; $display("FAIL bp_drain_count got=%0d exp=4", got.size()); end
        for (int i = 0; i < got.size() && i < 4; i++) begin
            total++; if (got[i] !== 164'(i + 1)) begin bad++; $display("FAIL bp_drain_data i=%0d got=%0h exp=%0h", i, got[i], i + 1); end
        end
    endtask

    task automatic test_toggle_stall();
        logic [163:0] q[$];
        logic [163:0] expd;
        int nxt;
        do_reset();
        nxt = 1;
        for (int c = 0; c < 44; c++) begin
            v2 = (c < 30);
            s2 = c[0];
            d2 = 164'(nxt);
            total++; if (int'(occ2) != q.size() || occ2 > 3'd4) begin bad++; $display("FAIL toggle_occ c=%0d got=%0d exp=%0d", c, occ2, q.size()); end
            if (ov2 && !s2) begin
                expd = (q.size() > 0) ? q.pop_front() : '1;
                total++; if (od2 !== expd) begin bad++; $display("FAIL toggle_data c=%0d got=%0h exp=%0h", c, od2, expd); end
            end
            if (v2 && !is2) begin
                q.push_back(d2);
                nxt++;
            end
            step();
        end
        total++; if (q.size() != 0 || nxt < 10) begin bad++; $display("FAIL toggle_loss left=%0d sent=%0d exp=0/>=10", q.size(), nxt - 1); end
        v2 = 1'b0;
        s2 = 1'b0;
    endtask

    task automatic test_midreset();
        int nxt;
        do_reset();
        s2  = 1'b1;
        nxt = 1;
        for (int c = 0; c < 3; c++) begin
            v2 = 1'b1;
            d2 = 164'(nxt + 8'h30);
            if (!is2) nxt++;
            step();
        end
        v2 = 1'b0;
        total++; if (occ2 !== 3'd3 || ov2 !== 1'b1) begin bad++; $display("FAIL mid_pre occ=%0d vld=%0h exp=3/1", occ2, ov2); end
        #2 arst_l = 1'b0;
        #1;
        total++; if (ov2 !== 1'b0) begin bad++; $display("FAIL mid_ov2 got=%0h exp=0", ov2); end
        total++; if (is2 !== 1'b0) begin bad++; $display("FAIL mid_is2 got=%0h exp=0", is2); end
        total++; if (occ2 !== 3'd0) begin bad++; $display("FAIL mid_occ2 got=%0d exp=0", occ2); end
        total++; if (od2 !== 164'd0) begin bad++; $display("FAIL mid_od2 got=%0h exp=0", od2); end
        #2 arst_l = 1'b1;
        s2 = 1'b0;
        step();
        for (int c = 0; c < 6; c++) begin
            total++; if (ov2 !== 1'b0) begin bad++; $display("FAIL mid_ghost c=%0d got=%0h exp=0 data=%0h", c, ov2, od2); end
            step();
        end
    endtask

    task automatic test_protocol_hold();
        int nxt;
        logic taken;
        logic [7:0] got[$];
        logic [7:0] expd;
        do_reset();
        s2  = 1'b1;
        nxt = 1;
        for (int c = 0; c < 6; c++) begin
            v2 = 1'b1;
            d2 = 164'(nxt);
            if (!is2) nxt++;
            step();
        end
        for (int c = 0; c < 2; c++) begin
            d2 = 164'h55;
            total++; if (is2 !== 1'b1) begin bad++; $display("FAIL hold_stalled c=%0d got=%0h exp=1", c, is2); end
            step();
        end
        d2    = 164'h66;
        s2    = 1'b0;
        taken = 1'b0;
        for (int c = 0; c < 16; c++) begin
            v2 = !taken;
            if (ov2) got.push_back(od2[7:0]);
            if (v2 && !is2) taken = 1'b1;
            step();
        end
        v2 = 1'b0;
        total++; if (got.size() != 5) begin bad++; $display("FAIL hold_count got=%0d exp=5", got.size()); end
        for (int i = 0; i < got.size() && i < 5; i++) begin
            expd = (i < 4) ? 8'(i + 1) : 8'h66;
            total++; if (got[i] !== expd) begin bad++; $display("FAIL hold_data i=%0d got=%0h exp=%0h", i, got[i], expd); end
        end
    endtask

    task automatic test_param_sweep();
        int first1, first4, n1, n4, sent1, sent4, got1, got4;
        logic acc1, acc4;
        logic [7:0] q1[$];
        logic [7:0] q4[$];
        logic [7:0] expd;
        localparam int N = 10000;

        do_reset();
        first1 = -1; first4 = -1;
        v1 = 1'b1; d1 = 8'hA1; v4 = 1'b1; d4 = 8'hA4;
        for (int c = 0; c < 10; c++) begin
            if (ov1 && first1 < 0) first1 = c;
            if (ov4 && first4 < 0) first4 = c;
            step();
            v1 = 1'b0; v4 = 1'b0;
        end
        total++; if (first1 != 1) begin bad++; $display("FAIL sweep_lat1 got=%0d exp=1", first1); end
        total++; if (first4 != 4) begin bad++; $display("FAIL sweep_lat4 got=%0d exp=4", first4); end

        do_reset();
        s1 = 1'b1; s4 = 1'b1; n1 = 0; n4 = 0;
        for (int c = 0; c < 14; c++) begin
            v1 = 1'b1; d1 = 8'(n1); v4 = 1'b1; d4 = 8'(n4);
            if (!is1) n1++;
            if (!is4) n4++;
            step();
        end
        total++; if (n1 != 2 || occ1 !== 3'd2 || is1 !== 1'b1) begin bad++; $display("FAIL sweep_cap1 got=%0d/%0d/%0h exp=2/2/1", n1, occ1, is1); end
        total++; if (n4 != 8 || occ4 !== 4'd8 || is4 !== 1'b1) begin bad++; $display("FAIL sweep_cap4 got=%0d/%0d/%0h exp=8/8/1", n4, occ4, is4); end

        do_reset();
        sent1 = 0; sent4 = 0; got1 = 0; got4 = 0;
        for (int cyc = 0; cyc < 60000 && (got1 < N || got4 < N); cyc++) begin
            if (!v1 && sent1 < N && $urandom_range(0, 3) != 0) begin v1 = 1'b1; d1 = 8'($urandom); end
            if (!v4 && sent4 < N && $urandom_range(0, 3) != 0) begin v4 = 1'b1; d4 = 8'($urandom); end
            s1 = ($urandom_range(0, 2) == 0);
            s4 = ($urandom_range(0, 2) == 0);
            total++; if (int'(occ1) != q1.size() || occ1 > 3'd2) begin bad++; $display("FAIL rnd_occ1 c=%0d got=%0d exp=%0d", cyc, occ1, q1.size()); end
            total++; if (int'(occ4) != q4.size() || occ4 > 4'd8) begin bad++; $display("FAIL rnd_occ4 c=%0d got=%0d exp=%0d", cyc, occ4, q4.size()); end
            if (ov1 && !s1) begin
                expd = (q1.size() > 0) ? q1.pop_front() : ~od1;
                got1++;
                total++; if (od1 !== expd) begin bad++; $display("FAIL rnd_data1 c=%0d got=%0h exp=%0h", cyc, od1, expd); end
            end
            if (ov4 && !s4) begin
                expd = (q4.size() > 0) ? q4.pop_front() : ~od4;
                got4++;
                total++; if (od4 !== expd) begin bad++; $display("FAIL rnd_data4 c=%0d got=%0h exp=%0h", cyc, od4, expd); end
            end
            acc1 = v1 & ~is1;
            acc4 = v4 & ~is4;
            if (acc1) begin q1.push_back(d1); sent1++; end
            if (acc4) begin q4.push_back(d4); sent4++; end
            step();
            if (acc1) v1 = 1'b0;
            if (acc4) v4 = 1'b0;
        end
        total++; if (got1 != N || q1.size() != 0) begin bad++; $display("FAIL rnd_done1 got=%0d left=%0d exp=%0d/0", got1, q1.size(), N); end
        total++; if (got4 != N || q4.size() != 0) begin bad++; $display("FAIL rnd_done4 got=%0d left=%0d exp=%0d/0", got4, q4.size(), N); end
        idle_inputs();
    endtask

    initial begin
        idle_inputs();
        test_reset();
        test_streaming();
        test_backpressure();
        test_toggle_stall();
        test_midreset();
        test_protocol_hold();
        test_param_sweep();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/sctag_pcx_rptr_pipe.md
# sctag_pcx_rptr_pipe

Parametrised, registered repeater for the PCX→sctag and sctag→PCX long-haul wires. It replaces the pure-wire repeater with `STAGES` flop stages. Each stage is a two-entry skid buffer, so valid/stall flow control is fully registered in both directions and no combinational path crosses the block. It sits on the channel between the crossbar and the sctag and carries an arbitrary-width packet plus a handshake.

## Interface
- `WIDTH`, default 164: payload bits per transfer.
- `STAGES`, default 2: number of pipeline stages; legal range 1..4.
- `OCCW`, default 3: width of `occ`; must satisfy 2^OCCW > 2*STAGES.

- `rclk`  in  1  clock; all state on the rising edge.
- `arst_l`  in  1  asynchronous, active-low reset.
- `in_data`  in  WIDTH  payload from the upstream sender.
- `in_vld`  in  1  `in_data` is valid this cycle.
- `in_stall`  out  1  block cannot accept; upstream must hold `in_vld`/`in_data`.
- `out_data`  out  WIDTH  payload to the downstream receiver.
- `out_vld`  out  1  `out_data` is valid this cycle.
- `out_stall`  in  1  downstream cannot accept this cycle.
- `occ`  out  OCCW  total entries held across all stages, 0..2*STAGES.

## Operation
- Transfer rules:
  - Input transfer occurs when `in_vld & ~in_stall`.
  - Output transfer occurs when `out_vld & ~out_stall`.
  - `in_vld` while `in_stall` is high: not accepted, no state change. Upstream holds the data.
- Stage chain: stage 0 faces the input and stage STAGES-1 drives the output. Each stage k has a main register M, a skid register S, and a state EMPTY/ONE/TWO.
  - Stage k's upstream handshake is stage k-1's downstream handshake. `rdy_k = (state_k != TWO)`, taken directly from the state flop.
  - Stage valid = `state != EMPTY`; stage data = M.
  - `push` = upstream valid & `rdy_k`; `pop` = stage valid & downstream ready.
- State transitions:
  - EMPTY: push → ONE, M←in.
  - ONE: push&pop → ONE, M←in. push&~pop → TWO, S←in. ~push&pop → EMPTY. Otherwise hold.
  - TWO: push is impossible. pop → ONE, M←S. Otherwise hold.
- Port mapping:
  - `in_stall = ~rdy_0`.
  - `out_vld`/`out_data` = stage STAGES-1 valid/M.
  - The ready of stage STAGES-1 downstream = `~out_stall`.
- Ordering: strict FIFO. No drop, no duplication, no reorder.
- `occ`: registered sum over stages of (ONE→1, TWO→2). It is updated in the same edge as the state flops.
- `out_data` while `out_vld`=0 holds its last value (0 after reset). Receivers must qualify it with `out_vld`.

## Timing
- Reset values, asynchronous on `arst_l` low:
  - All stages EMPTY; M=S=0.
  - `out_vld`=0, `in_stall`=0, `out_data`=0, `occ`=0.
- Release of reset is synchronous to `rclk`. First accept is possible on the first edge after deassertion.
- Latency: an item accepted at edge N appears on `out_vld` after edge N+STAGES-1, i.e. STAGES cycles, when no stalls are present.
- Throughput: 1 transfer per cycle sustained with `out_stall`=0.
- Stall propagation:
  - `out_stall` reaches `in_stall` after at most STAGES cycles.
  - Capacity is 2*STAGES items.
  - Entries absorbed after `out_stall` rises are at most STAGES (one skid per stage).
- Simultaneous push and pop in ONE: the new item replaces M and the count is unchanged.
- Simultaneous events in TWO: only pop is possible.
- Reset mid-traffic: all in-flight entries are discarded and outputs go to reset values immediately. Upstream must reissue.
- `out_stall` may toggle every cycle. `in_stall` depends only on flops.

## Test plan
- Streaming: WIDTH=164, STAGES=2, `out_stall`=0. Drive 10 back-to-back items 0x1..0xA. Required: `out_vld` first rises 2 cycles after the first accept, items 0x1..0xA emerge on consecutive cycles, and `occ` holds at 2 in steady state.
- Backpressure fill: STAGES=2, `out_stall` held at 1, `in_vld` held at 1. Required: exactly 4 items accepted, `occ`=4, `in_stall`=1. Releasing `out_stall` drains all 4 in order, 4 cycles of `out_vld`, with no loss.
- Toggling stall: `out_stall` alternates 1/0 each cycle with continuous input. Required: no loss, no duplication, order preserved, `occ` never exceeds 4.
- Reset mid-operation: with 3 items held, pulse `arst_l` low asynchronously (between edges). Required: `out_vld`=0, `in_stall`=0, `occ`=0, `out_data`=0 immediately. No pre-reset item appears afterwards.
- Parameter sweep: STAGES=1 and STAGES=4 with WIDTH=8.
  - STAGES=1: latency 1, capacity 2.
  - STAGES=4: latency 4, capacity 8.
  - Random `in_vld`/`out_stall`, scoreboard compare over 10k items.
- Protocol hold: assert `in_vld` with value 0x55 while `in_stall`=1, then change the data to 0x66 before the stall clears. Required: 0x55 is not accepted; only values presented while `in_stall`=0 appear at the output.
